state_mux_n: RTL and testbench

- Registered N-way selector for sparse Keccak state busses (LANES x LANE_W lanes), with a round tag carried at the same latency.
- Generalises the 2-way 1600-bit mux in three ways: parametrised input count, two selection modes (explicit select or round-robin arbitration), and a valid/ready handshake on every port.
- Sits between the round pipeline feedback, the absorb/padding front-end and any extra hashing channels, in front of the permutation core's input.

---
 rtl/state_mux_n.sv | 114 +++++++++++
 tb/tb_state_mux_n.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/state_mux_n.sv
// Registered N-way selector for Keccak state busses with a round tag at equal latency.
// Supports explicit select or round-robin arbitration, with valid/ready on every port.
module state_mux_n #(
  parameter int NUM_IN  = 2,
  parameter int LANES   = 25,
  parameter int LANE_W  = 64,
  parameter int ROUND_W = 6,
  parameter int SEL_W   = $clog2(NUM_IN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IN-1:0]  ivalid,
  output logic [NUM_IN-1:0]  iready,
  input  logic [LANE_W-1:0]  idata [NUM_IN][LANES],
  input  logic [ROUND_W-1:0] iround [NUM_IN],
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic               ovalid,
  input  logic               oready,
  output logic [LANE_W-1:0]  odata [LANES],
  output logic [ROUND_W-1:0] oround,
  output logic [SEL_W-1:0]   osrc
);

  // Handshake: a transfer occurs on channel k in a cycle where ivalid[k] && iready[k]
  // at the rising edge; the output side transfers when ovalid && oready.

  logic               ovalid_q, ovalid_d;
  logic [LANE_W-1:0]  odata_q [LANES];
  logic [LANE_W-1:0]  odata_d [LANES];
  logic [ROUND_W-1:0] oround_q, oround_d;
  logic [SEL_W-1:0]   osrc_q, osrc_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  logic [SEL_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               load;

  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_IN) s = s - NUM_IN;
    return s[SEL_W-1:0];
  endfunction

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (!mode) begin
      // Out-of-range select (non power-of-2 NUM_IN) grants nothing.
      if (int'(sel) < NUM_IN) begin
        grant_idx   = sel;
        grant_valid = ivalid[sel];
      end
    end else begin
      // Walk downward so the candidate closest to ptr wins.
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (ivalid[wrap_add(ptr_q, i)]) begin
          grant_idx   = wrap_add(ptr_q, i);
          grant_valid = 1'b1;
        end
      end
    end
  end

  // Reset gates load so no upstream transfer is accepted while rst is high.
  assign load = !rst && (!ovalid_q || oready) && grant_valid;

  always_comb begin
    iready = '0;
    if (load) iready[grant_idx] = 1'b1;
  end

  always_comb begin
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    oround_d = oround_q;
    osrc_d   = osrc_q;
    ptr_d    = ptr_q;
    if (load) begin
      ovalid_d = 1'b1;
      odata_d  = idata[grant_idx];
      oround_d = iround[grant_idx];
      osrc_d   = grant_idx;
      if (mode) begin
        ptr_d = (int'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (oready) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovalid_q <= 1'b0;
      odata_q  <= '{default: '0};
      oround_q <= '0;
      osrc_q   <= '0;
      ptr_q    <= '0;
    end else begin
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      oround_q <= oround_d;
      osrc_q   <= osrc_d;
      ptr_q    <= ptr_d;
    end
  end

  assign ovalid = ovalid_q;
  assign odata  = odata_q;
  assign oround = oround_q;
  assign osrc   = osrc_q;

endmodule

// File: tb/tb_state_mux_n.sv
// Self-checking bench for state_mux_n: 4-way instance for arbitration and flow control,
// 2-way for explicit select, 3-way for out-of-range select.
module tb_state_mux_n;

  localparam int LN = 25;
  localparam int LW = 64;
  localparam int RW = 6;
  localparam int W  = 4 + RW + 2 * LW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-way instance
  logic [3:0]    a_ivalid, a_iready;
  logic [LW-1:0] a_idata [4][LN];
  logic [RW-1:0] a_iround [4];
  logic          a_mode, a_ovalid, a_oready;
  logic [1:0]    a_sel, a_osrc;
  logic [LW-1:0] a_odata [LN];
  logic [RW-1:0] a_oround;

  // 3-way instance
  logic [2:0]    b_ivalid, b_iready;
  logic [LW-1:0] b_idata [3][LN];
  logic [RW-1:0] b_iround [3];
  logic          b_mode, b_ovalid, b_oready;
  logic [1:0]    b_sel, b_osrc;
  logic [LW-1:0] b_odata [LN];
  logic [RW-1:0] b_oround;

  // 2-way instance
  logic [1:0]    c_ivalid, c_iready;
  logic [LW-1:0] c_idata [2][LN];
  logic [RW-1:0] c_iround [2];
  logic          c_mode, c_ovalid, c_oready;
  logic [0:0]    c_sel, c_osrc;
  logic [LW-1:0] c_odata [LN];
  logic [RW-1:0] c_oround;

  state_mux_n #(.NUM_IN(4), .LANES(LN), .LANE_W(LW), .ROUND_W(RW)) u_a (
    .clk(clk), .rst(rst), .ivalid(a_ivalid), .iready(a_iready), .idata(a_idata),
    .iround(a_iround), .mode(a_mode), .sel(a_sel), .ovalid(a_ovalid), .oready(a_oready),
    .odata(a_odata), .oround(a_oround), .osrc(a_osrc)
  );

  state_mux_n #(.NUM_IN(3), .LANES(LN), .LANE_W(LW), .ROUND_W(RW)) u_b (
    .clk(clk), .rst(rst), .ivalid(b_ivalid), .iready(b_iready), .idata(b_idata),
    .iround(b_iround), .mode(b_mode), .sel(b_sel), .ovalid(b_ovalid), .oready(b_oready),
    .odata(b_odata), .oround(b_oround), .osrc(b_osrc)
  );

  state_mux_n #(.NUM_IN(2), .LANES(LN), .LANE_W(LW), .ROUND_W(RW)) u_c (
    .clk(clk), .rst(rst), .ivalid(c_ivalid), .iready(c_iready), .idata(c_idata),
    .iround(c_iround), .mode(c_mode), .sel(c_sel), .ovalid(c_ovalid), .oready(c_oready),
    .odata(c_odata), .oround(c_oround), .osrc(c_osrc)
  );

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // Reference model state for the 4-way instance.
  logic [1:0]   m_ptr = 2'd0;
  logic         m_ovalid = 1'b0;
  logic [W-1:0] a_last = '0;
  logic [1:0]   a_obs_src;
  logic         a_obs_load;

  // One cycle on the 4-way instance: drive at negedge, check iready, check output after posedge.
  task automatic a_cycle(input logic [3:0] v, input logic md, input logic [1:0] s, input logic ordy);
    logic [1:0]   g, idx;
    logic         gv, ld;
    logic [3:0]   er;
    logic [W-1:0] got;
    @(negedge clk);
    a_ivalid = v;
    a_mode   = md;
    a_sel    = s;
    a_oready = ordy;
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < LN; l++) a_idata[k][l] = {$urandom, $urandom};
      a_iround[k] = RW'($urandom_range(0, 63));
    end
    #1;
    g  = 2'd0;
    gv = 1'b0;
    if (!md) begin
      g  = s;
      gv = v[s];
    end else begin
      for (int i = 0; i < 4; i++) begin
        idx = m_ptr + 2'(i);
        if (!gv && v[idx]) begin
          g  = idx;
          gv = 1'b1;
        end
      end
    end
    ld = gv && (!m_ovalid || ordy);
    er = ld ? (4'b0001 << g) : 4'b0000;
    total++;
    if (a_iready !== er) begin
      bad++;
      $display("FAIL a_iready got=%b exp=%b", a_iready, er);
    end
    if (ld) begin
      exp_q.push_back({2'b00, g, a_iround[g], a_idata[g][0], a_idata[g][LN-1]});
      if (md) m_ptr = g + 2'd1;
    end
    @(posedge clk);
    #1;
    a_obs_load = ld;
    if (ld) begin
      m_ovalid = 1'b1;
      a_last   = exp_q.pop_front();
    end else if (ordy) begin
      m_ovalid = 1'b0;
    end
    got = {2'b00, a_osrc, a_oround, a_odata[0], a_odata[LN-1]};
    total++;
    if (a_ovalid !== m_ovalid) begin
      bad++;
      $display("FAIL a_ovalid got=%b exp=%b", a_ovalid, m_ovalid);
    end
    total++;
    if (got !== a_last) begin
      bad++;
      $display("FAIL a_output got=%h exp=%h", got, a_last);
    end
    a_obs_src = a_osrc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({a_ovalid, b_ovalid, c_ovalid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ovalid got=%b exp=000", {a_ovalid, b_ovalid, c_ovalid});
    end
    // Move ptr off zero and leave ovalid=1 with a nonzero source.
    a_cycle(4'b0010, 1'b1, 2'd0, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({a_ovalid, a_osrc, a_oround, a_odata[0], a_iready} !== '0) begin
      bad++;
      $display("FAIL reset_async got=%b/%0d/%0d/%h/%b exp=0", a_ovalid, a_osrc, a_oround, a_odata[0], a_iready);
    end
    a_ivalid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    m_ptr    = 2'd0;
    m_ovalid = 1'b0;
    a_last   = '0;
    exp_q.delete();
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [4];
    seq = '{2'd0, 2'd2, 2'd0, 2'd2};
    for (int i = 0; i < 8; i++) begin
      a_cycle(4'hF, 1'b1, 2'd0, 1'b1);
      total++;
      if (a_obs_src !== 2'(i % 4)) begin
        bad++;
        $display("FAIL rr_all step=%0d got=%0d exp=%0d", i, a_obs_src, i % 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      a_cycle(4'b0101, 1'b1, 2'd0, 1'b1);
      total++;
      if (a_obs_src !== seq[i]) begin
        bad++;
        $display("FAIL rr_sparse step=%0d got=%0d exp=%0d", i, a_obs_src, seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    a_cycle(4'hF, 1'b1, 2'd0, 1'b1);
    held = a_last;
    repeat (3) a_cycle(4'hF, 1'b1, 2'd0, 1'b0);
    total++;
    if ({2'b00, a_osrc, a_oround, a_odata[0], a_odata[LN-1]} !== held) begin
      bad++;
      $display("FAIL bp_hold got=%0d/%0d exp=%h", a_osrc, a_oround, held);
    end
    a_cycle(4'hF, 1'b1, 2'd0, 1'b1);
    total++;
    if (a_obs_load !== 1'b1) begin
      bad++;
      $display("FAIL bp_release load=%b exp=1", a_obs_load);
    end
  endtask

  task automatic test_drain();
    a_cycle(4'b0000, 1'b1, 2'd0, 1'b1);
    a_cycle(4'b0000, 1'b0, 2'd1, 1'b1);
    total++;
    if (a_ovalid !== 1'b0) begin
      bad++;
      $display("FAIL drain_ovalid got=%b exp=0", a_ovalid);
    end
  endtask

  task automatic test_mode_switch();
    a_cycle(4'b0010, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      a_cycle(4'hF, 1'b0, 2'd0, 1'b1);
      total++;
      if (a_obs_src !== 2'd0) begin
        bad++;
        $display("FAIL mode_sel0 got=%0d exp=0", a_obs_src);
      end
    end
    a_cycle(4'hF, 1'b1, 2'd0, 1'b1);
    total++;
    if (a_obs_src !== 2'd2) begin
      bad++;
      $display("FAIL mode_rr_resume got=%0d exp=2", a_obs_src);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      a_cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 3) != 0));
    end
    a_cycle(4'b0000, 1'b1, 2'd0, 1'b1);
  endtask

  task automatic test_explicit_sel();
    logic [W-1:0] e, got;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      c_mode = 1'b0;
      c_sel = 1'b1;
      c_ivalid = 2'b11;
      c_oready = 1'b1;
      c_idata[0][0] = {$urandom, $urandom};
      c_idata[1][0] = (i == 0) ? 64'hDEAD_BEEF : {$urandom, $urandom};
      c_idata[1][LN-1] = {$urandom, $urandom};
      c_iround[0] = RW'(i + 9);
      c_iround[1] = RW'(i + 5);
      exp_q.push_back({3'b000, 1'b1, c_iround[1], c_idata[1][0], c_idata[1][LN-1]});
      #1;
      total++;
      if (c_iready !== 2'b10) begin
        bad++;
        $display("FAIL sel_iready got=%b exp=10", c_iready);
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      got = {3'b000, c_osrc, c_oround, c_odata[0], c_odata[LN-1]};
      total++;
      if (c_ovalid !== 1'b1 || got !== e) begin
        bad++;
        $display("FAIL sel_output v=%b got=%h exp=%h", c_ovalid, got, e);
      end
      if (i == 0) begin
        total++;
        if (c_odata[0] !== 64'hDEAD_BEEF || c_oround !== 6'd5 || c_osrc !== 1'b1) begin
          bad++;
          $display("FAIL sel_literal got=%h/%0d/%0d exp=deadbeef/5/1", c_odata[0], c_oround, c_osrc);
        end
      end
    end
  endtask

  task automatic test_invalid_sel();
    @(negedge clk);
    b_mode = 1'b0;
    b_sel = 2'd3;
    b_ivalid = 3'b111;
    b_oready = 1'b1;
    #1;
    total++;
    if (b_iready !== 3'b000) begin
      bad++;
      $display("FAIL badsel_iready got=%b exp=000", b_iready);
    end
    @(posedge clk);
    #1;
    total++;
    if (b_ovalid !== 1'b0) begin
      bad++;
      $display("FAIL badsel_ovalid got=%b exp=0", b_ovalid);
    end
    @(negedge clk);
    b_sel = 2'd2;
    b_iround[2] = 6'd33;
    b_idata[2][0] = 64'h0123_4567_89AB_CDEF;
    #1;
    total++;
    if (b_iready !== 3'b100) begin
      bad++;
      $display("FAIL sel2_iready got=%b exp=100", b_iready);
    end
    @(posedge clk);
    #1;
    total++;
    if (b_ovalid !== 1'b1 || b_osrc !== 2'd2 || b_oround !== 6'd33 || b_odata[0] !== 64'h0123_4567_89AB_CDEF) begin
      bad++;
      $display("FAIL sel2_output got=%b/%0d/%0d/%h exp=1/2/33/0123456789abcdef", b_ovalid, b_osrc, b_oround, b_odata[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_ivalid = '0; a_mode = 1'b0; a_sel = '0; a_oready = 1'b0;
    b_ivalid = '0; b_mode = 1'b0; b_sel = '0; b_oready = 1'b0;
    c_ivalid = '0; c_mode = 1'b0; c_sel = '0; c_oready = 1'b0;
    a_idata = '{default: '{default: '0}};
    b_idata = '{default: '{default: '0}};
    c_idata = '{default: '{default: '0}};
    a_iround = '{default: '0};
    b_iround = '{default: '0};
    c_iround = '{default: '0};
    test_reset();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_mode_switch();
    test_back_to_back();
    test_explicit_sel();
    test_invalid_sel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
